// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and next-address selection for the
// single-cycle core. Owns the RUN/STALL/HALT sequencing, the resumable
// halt and modulo-2**ADDR_WIDTH address arithmetic.
// Optional feature macro: FETCH_RAS_EN builds a circular hardware
// return-address stack. jal pushes onto it and jump_reg pops from it.
// Without the macro, jump_reg always targets target_reg and the RAS
// flags read 0.
module pc_fetch_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  resume,
  input  logic                  wait_io,
  input  logic                  jump,
  input  logic                  jump_reg,
  input  logic                  jal,
  input  logic                  branch_uc,
  input  logic                  branch_alu,
  input  logic [ADDR_WIDTH-1:0] target_imm,
  input  logic [DATA_WIDTH-1:0] target_reg,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] link_addr,
  output logic                  halted,
  output logic                  stalled,
  output logic                  ras_overflow,
  output logic                  ras_underflow
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   ret_target;

  // Only the low ADDR_WIDTH bits of a register target address the ROM.
  logic unused_target_hi;
  assign unused_target_hi = &{1'b0, target_reg[DATA_WIDTH-1:ADDR_WIDTH]};

  // The adder width gives the wrap from the last word back to 0.
  assign pc_inc    = pc_q + 1'b1;
  assign pc        = pc_q;
  assign link_addr = DATA_WIDTH'(pc_inc);
  assign halted    = (state_q == ST_HALT);
  assign stalled   = (state_q == ST_STALL);

`ifdef FETCH_RAS_EN
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] ras_mem [STACK_DEPTH];
  logic [PW-1:0]         ras_ptr_q, ras_ptr_d, ras_ptr_pop;
  logic [CW-1:0]         ras_cnt_q, ras_cnt_d, ras_cnt_pop;
  logic                  ras_ovf_q, ras_ovf_d;
  logic                  ras_unf_q, ras_unf_d;
  logic                  run_go, do_push, do_pop, ras_empty;

  // The stack only moves when the core actually advances in RUN.
  assign run_go    = (state_q == ST_RUN) && !halt && !wait_io;
  assign do_push   = run_go && jal;
  assign do_pop    = run_go && jump_reg;
  assign ras_empty = (ras_cnt_q == '0);

  // ras_ptr_q points at the next free slot; the top is one below it.
  assign ret_target = ras_empty ? target_reg[ADDR_WIDTH-1:0]
                                : ras_mem[ras_ptr_q - 1'b1];

  assign ras_overflow  = ras_ovf_q;
  assign ras_underflow = ras_unf_q;

  // Stack pointer/count update: pop first, then push into the freed slot.
  always_comb begin
    ras_ptr_pop = ras_ptr_q;
    ras_cnt_pop = ras_cnt_q;
    ras_ovf_d   = ras_ovf_q;
    ras_unf_d   = ras_unf_q;
    if (do_pop) begin
      if (ras_empty) begin
        ras_unf_d = 1'b1;
      end else begin
        ras_ptr_pop = ras_ptr_q - 1'b1;
        ras_cnt_pop = ras_cnt_q - 1'b1;
      end
    end
    ras_ptr_d = ras_ptr_pop;
    ras_cnt_d = ras_cnt_pop;
    if (do_push) begin
      ras_ptr_d = ras_ptr_pop + 1'b1;
      if (ras_cnt_pop == DEPTH_C) begin
        // Full: the write lands on the oldest entry, count stays at depth.
        ras_ovf_d = 1'b1;
      end else begin
        ras_cnt_d = ras_cnt_pop + 1'b1;
      end
    end
  end

  // Stack control registers; reset empties the stack and clears the flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
    end
  end

  // Stack storage write; contents need no reset since the count gates reads.
  always_ff @(posedge clock) begin
    if (do_push) begin
      ras_mem[ras_ptr_pop] <= link_addr[ADDR_WIDTH-1:0];
    end
  end
`else
  logic unused_jal;
  assign unused_jal    = jal;
  assign ret_target    = target_reg[ADDR_WIDTH-1:0];
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // Next-state and next-PC selection; the first matching condition wins.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (wait_io) begin
          state_d = ST_STALL;
        end else if (jump_reg) begin
          pc_d = ret_target;
        end else if (jump) begin
          pc_d = target_imm;
        end else if (branch_uc && branch_alu) begin
          pc_d = target_imm;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_STALL: begin
        // Held instruction re-executes in the cycle after leaving STALL.
        if (!wait_io) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        // Resuming steps past the hlt instruction.
        if (resume) begin
          state_d = ST_RUN;
          pc_d    = pc_inc;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and PC registers with immediate reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver applies one decision
// vector per clock, advances a behavioural model and queues the expected
// post-edge outputs; a monitor pops and compares after every edge.
module tb_pc_fetch_unit;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NWORD = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          halt, resume, wait_io, jump, jump_reg, jal;
  logic          branch_uc, branch_alu;
  logic [AW-1:0] target_imm;
  logic [DW-1:0] target_reg;
  logic [AW-1:0] pc;
  logic [DW-1:0] link_addr;
  logic          halted, stalled, ras_overflow, ras_underflow;

  pc_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .halt(halt), .resume(resume),
    .wait_io(wait_io), .jump(jump), .jump_reg(jump_reg), .jal(jal),
    .branch_uc(branch_uc), .branch_alu(branch_alu),
    .target_imm(target_imm), .target_reg(target_reg),
    .pc(pc), .link_addr(link_addr), .halted(halted), .stalled(stalled),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pc;
    bit halted;
    bit stalled;
    int link;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;

  // Reference model: 0 = RUN, 1 = STALL, 2 = HALT.
  int   m_pc, m_state;
  bit   m_ovf, m_unf;
  int   m_stack[$];

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc    = 0;
    m_state = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step(input bit h, r, w, j, jr, jl, bu, ba,
                                     input int timm, input int treg_lo);
    int nxt;
    int link;
    link = (m_pc + 1) % NWORD;
    if (m_state == 2) begin
      if (r) begin
        m_state = 0;
        m_pc    = link;
      end
    end else if (m_state == 1) begin
      if (!w) m_state = 0;
    end else if (h) begin
      m_state = 2;
    end else if (w) begin
      m_state = 1;
    end else begin
      nxt = link;
      if (jr) begin
        nxt = treg_lo;
`ifdef FETCH_RAS_EN
        if (m_stack.size() > 0) nxt = m_stack.pop_back();
        else m_unf = 1;
`endif
      end else if (j || (bu && ba)) begin
        nxt = timm;
      end
`ifdef FETCH_RAS_EN
      if (jl) begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1;
        end
        m_stack.push_back(link);
      end
`endif
      m_pc = nxt;
    end
  endfunction

  // One clock: called at posedge+4, drives inputs for the coming edge.
  task automatic cyc(input bit h, r, w, j, jr, jl, bu, ba,
                     input int timm, input logic [DW-1:0] treg);
    exp_t e;
    logic [AW-1:0] ti;
    ti = timm[AW-1:0];
    halt = h; resume = r; wait_io = w; jump = j; jump_reg = jr; jal = jl;
    branch_uc = bu; branch_alu = ba;
    target_imm = ti; target_reg = treg;
    model_step(h, r, w, j, jr, jl, bu, ba, int'(ti), int'(treg[AW-1:0]));
    e.pc = m_pc;
    e.halted = (m_state == 2);
    e.stalled = (m_state == 1);
    e.link = (m_pc + 1) % NWORD;
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
    @(posedge clock);
    #4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic go_to(input int a);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, a, '0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
  task automatic mid_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_pc"}, int'(pc), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_stalled"}, int'(stalled), 0);
    chk({tag, "_ovf"}, int'(ras_overflow), 0);
    chk({tag, "_unf"}, int'(ras_underflow), 0);
    model_reset();
    @(posedge clock);
    #4;
    reset = 1'b0;
  endtask

  // Monitor: compares each queued expectation just after its clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d pc=%0d halted=%0b stalled=%0b link=%0d ovf=%0b unf=%0b",
                 n_txn, pc, halted, stalled, link_addr, ras_overflow, ras_underflow);
        chk("pc", int'(pc), e.pc);
        chk("halted", int'(halted), int'(e.halted));
        chk("stalled", int'(stalled), int'(e.stalled));
        chk("link_addr", int'(link_addr), e.link);
        chk("ras_overflow", int'(ras_overflow), int'(e.ovf));
        chk("ras_underflow", int'(ras_underflow), int'(e.unf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h, r, w, j, jr, jl;
    reset = 1'b1;
    halt = 0; resume = 0; wait_io = 0; jump = 0; jump_reg = 0; jal = 0;
    branch_uc = 0; branch_alu = 0; target_imm = '0; target_reg = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #4;
    reset = 1'b0;
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_stalled", int'(stalled), 0);

    // Sequential fetch from 0, then asynchronous reset.
    idle(5);
    mid_reset("async_rst");

    // Stall at pc 3, then halt with wait_io at pc 7 and resume.
    idle(3);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    idle(2);
    go_to(7);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 100, '0);
    cyc(1, 0, 1, 0, 1, 0, 1, 1, 55, 32'd12);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, '0);

    // Branch conditions and jump_reg priority.
    go_to(10);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 40, '0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 40, '0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 5, 32'd99);

    // Wrap at the top of the address space.
    go_to(NWORD - 2);
    idle(2);

    // jal chain and returns (stack unwinds when the stack is built).
    go_to(2);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 20, '0);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 30, '0);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 50, '0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd60);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd61);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd7);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hABCD_E123);

    // Reset from inside HALT and inside STALL.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    idle(1);
    mid_reset("rst_in_halt");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    mid_reset("rst_in_stall");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset("rand_rst");
      end else begin
        h  = ($urandom_range(0, 29) == 0);
        r  = ($urandom_range(0, 3) == 0);
        w  = ($urandom_range(0, 5) == 0);
        j  = ($urandom_range(0, 7) == 0);
        jr = ($urandom_range(0, 9) == 0);
        jl = j && !jr && ($urandom_range(0, 1) == 1);
        cyc(h, r, w, j, jr, jl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, NWORD - 1)), $urandom);
      end
    end

    @(posedge clock);
    #4;
    chk("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
